coin_round_controller: RTL and testbench
========================================

Name: coin_round_controller

Overview:
- Game-logic controller that sequences the four-coin sprite datapath.
- Once per frame it tests the character bounding box against each visible coin and clears the coins that are hit.
- Produces the 4-bit coin_display mask consumed by the coin renderer, plus a saturating score.
- Runs the round state machine: idle, playing, cleared, and automatic respawn after a frame delay.

Parameters:
- COIN0_X, 102, left x of coin 0 (leftmost coin).
- COIN_STEP, 52, x pitch between adjacent coins.
- COIN_Y, 54, top y of all coins.
- COIN_W, 31, coin width in pixels.
- COIN_H, 33, coin height in pixels.
- CHAR_W, 21, character width in pixels.
- CHAR_H, 32, character height in pixels.
- RESPAWN_FRAMES, 120, frame_tick count spent in CLEARED before auto-respawn (1..255).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, issued at vblank start.
- start  in  1  one-cycle pulse; begins a new game.
- char_left  in  10  character left x.
- char_top  in  10  character top y.
- coin_display  out  4  visible-coin mask; bit 3 = coin 0, bit 0 = coin 3.
- score  out  8  coins collected since start; saturates at 255.
- collect_pulse  out  1  one-cycle pulse when at least one coin is collected.
- collect_mask  out  4  coins collected on that pulse; 0 otherwise.
- all_collected  out  1  high while in CLEARED.
- round  out  4  rounds completed since start; wraps 15 -> 0.

Behaviour:
- Reset values (asynchronous, effective immediately): state IDLE, coin_display 0000, score 0, collect_pulse 0, collect_mask 0000, all_collected 0, round 0, pipeline idle, respawn counter 0.
- States:
  - IDLE: coin_display 0000; collision checks disabled.
  - PLAYING: collision pipeline active.
  - CLEARED: all_collected=1; coin_display 0000.
- start, sampled in any state:
  - Next edge: state PLAYING, coin_display 1111, score 0, round 0.
  - Any in-flight pipeline stage is flushed; no collect_pulse results from it.
  - start has priority over every other event in the same cycle.
- Collision pipeline (PLAYING only):
  - S0 (frame_tick edge N): register char_left and char_top; set busy.
  - S1 (N+1): compute the per-coin hit vector and register it.
  - Coin k spans x = COIN0_X + k*COIN_STEP, width COIN_W; y = COIN_Y, height COIN_H.
  - Hit when char_left < cx+COIN_W, char_left+CHAR_W > cx, char_top < COIN_Y+COIN_H and char_top+CHAR_H > COIN_Y.
  - All sums are formed in 11 bits; no wrap.
  - S2 (N+2): eff = hit & coin_display.
    - If eff is nonzero: coin_display &= ~eff; score += popcount(eff), saturating at 255; collect_pulse=1 and collect_mask=eff for exactly one cycle.
    - If the resulting coin_display is 0000: state becomes CLEARED on the same edge, round increments, respawn counter is cleared.
  - Latency from frame_tick to coin_display/score update is 2 cycles.
  - frame_tick arriving while busy is ignored; it is not queued.
  - Already-collected coins never re-score.
- CLEARED:
  - Each frame_tick increments the respawn counter.
  - On the tick that makes the count equal RESPAWN_FRAMES: state PLAYING, coin_display 1111; score is retained.
- frame_tick in IDLE is ignored.
- Simultaneous hits on several coins are all collected in the same S2 cycle.

Test Plan:
- Reset asserted mid-pipeline (between S0 and S2) -> outputs immediately return to reset values; no collect_pulse afterwards.
- start; frame_tick with char_left=90, char_top=60 -> 2 cycles later coin_display=0111, score=1, collect_pulse for 1 cycle with collect_mask=1000; a repeat frame_tick at the same position leaves score=1.
- After start, char_left=140, char_top=60, frame_tick -> coin_display=1011, collect_mask=0100. Then char_top=100 (below coins) -> no change.
- CHAR_W=40 override; char_left=120, char_top=60, frame_tick -> collect_mask=1100, score+=2 in a single pulse.
- RESPAWN_FRAMES=3; collect all 4 coins -> all_collected=1, round=1, coin_display=0000. The third subsequent frame_tick -> coin_display=1111, all_collected=0, score=4 retained.
- frame_tick 1 cycle after a prior frame_tick -> ignored. Separately, start asserted in the same cycle as S2 with a hit -> score=0, coin_display=1111, no collect_pulse.

Source files
------------

// File: rtl/coin_round_controller.sv
// Round controller for the four-coin game: per-frame bounding-box collision pipeline,
// visible-coin mask, saturating score, round counter and timed respawn.
module coin_round_controller #(
    parameter int unsigned COIN0_X        = 102,
    parameter int unsigned COIN_STEP      = 52,
    parameter int unsigned COIN_Y         = 54,
    parameter int unsigned COIN_W         = 31,
    parameter int unsigned COIN_H         = 33,
    parameter int unsigned CHAR_W         = 21,
    parameter int unsigned CHAR_H         = 32,
    parameter int unsigned RESPAWN_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] char_left,
    input  logic [9:0] char_top,
    output logic [3:0] coin_display,
    output logic [7:0] score,
    output logic       collect_pulse,
    output logic [3:0] collect_mask,
    output logic       all_collected,
    output logic [3:0] round
);

    typedef enum logic [1:0] {StIdle, StPlaying, StCleared} state_e;

    state_e     state_q, state_d;
    logic [3:0] disp_q, disp_d;
    logic [7:0] score_q, score_d;
    logic       pulse_q, pulse_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] round_q, round_d;
    logic [7:0] cnt_q, cnt_d;
    logic       s1_vld_q, s1_vld_d;
    logic       s2_vld_q, s2_vld_d;
    logic [9:0] cl_q, cl_d;
    logic [9:0] ct_q, ct_d;
    logic [3:0] hit_q, hit_d;
    logic [3:0] hit_c;

    // Bit 3 is coin 0 (leftmost); all bounds compared in 11 bits so sums never wrap.
    always_comb begin
        logic [10:0] cx;
        logic [10:0] l11;
        logic [10:0] t11;
        l11   = {1'b0, cl_q};
        t11   = {1'b0, ct_q};
        hit_c = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cx = 11'(COIN0_X + k * COIN_STEP);
            hit_c[3-k] = (l11 < cx + 11'(COIN_W)) && (l11 + 11'(CHAR_W) > cx) &&
                         (t11 < 11'(COIN_Y + COIN_H)) && (t11 + 11'(CHAR_H) > 11'(COIN_Y));
        end
    end

    always_comb begin
        logic [3:0] eff;
        logic [2:0] pop;
        logic [8:0] sum;
        logic       busy;
        state_d  = state_q;
        disp_d   = disp_q;
        score_d  = score_q;
        pulse_d  = 1'b0;
        mask_d   = 4'b0000;
        round_d  = round_q;
        cnt_d    = cnt_q;
        s1_vld_d = 1'b0;
        s2_vld_d = 1'b0;
        cl_d     = cl_q;
        ct_d     = ct_q;
        hit_d    = hit_q;
        eff      = hit_q & disp_q;
        pop      = {2'b00, eff[0]} + {2'b00, eff[1]} + {2'b00, eff[2]} + {2'b00, eff[3]};
        sum      = {1'b0, score_q} + {6'b000000, pop};
        busy     = s1_vld_q | s2_vld_q;

        if (start) begin
            // Pipeline valids drop to zero, flushing any in-flight collision.
            state_d = StPlaying;
            disp_d  = 4'b1111;
            score_d = 8'd0;
            round_d = 4'd0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StPlaying: begin
                    hit_d    = hit_c;
                    s2_vld_d = s1_vld_q;
                    if (frame_tick && !busy) begin
                        s1_vld_d = 1'b1;
                        cl_d     = char_left;
                        ct_d     = char_top;
                    end
                    if (s2_vld_q && (eff != 4'b0000)) begin
                        disp_d  = disp_q & ~eff;
                        score_d = sum[8] ? 8'hFF : sum[7:0];
                        pulse_d = 1'b1;
                        mask_d  = eff;
                        if ((disp_q & ~eff) == 4'b0000) begin
                            state_d = StCleared;
                            round_d = round_q + 4'd1;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                StCleared: begin
                    if (frame_tick) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == 8'(RESPAWN_FRAMES)) begin
                            state_d = StPlaying;
                            disp_d  = 4'b1111;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            disp_q   <= 4'b0000;
            score_q  <= 8'd0;
            pulse_q  <= 1'b0;
            mask_q   <= 4'b0000;
            round_q  <= 4'd0;
            cnt_q    <= 8'd0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            cl_q     <= 10'd0;
            ct_q     <= 10'd0;
            hit_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            score_q  <= score_d;
            pulse_q  <= pulse_d;
            mask_q   <= mask_d;
            round_q  <= round_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            cl_q     <= cl_d;
            ct_q     <= ct_d;
            hit_q    <= hit_d;
        end
    end

    assign coin_display  = disp_q;
    assign score         = score_q;
    assign collect_pulse = pulse_q;
    assign collect_mask  = mask_q;
    assign all_collected = (state_q == StCleared);
    assign round         = round_q;

endmodule

// File: tb/tb_coin_round_controller.sv
// Bench for coin_round_controller: default instance checked via a pulse scoreboard,
// plus a wide-character, short-respawn instance checked inline.
module tb_coin_round_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] char_left = 10'd0;
    logic [9:0] char_top = 10'd0;

    logic [3:0] coin_display_a, collect_mask_a, round_a;
    logic [7:0] score_a;
    logic       collect_pulse_a, all_collected_a;
    logic [3:0] coin_display_b, collect_mask_b, round_b;
    logic [7:0] score_b;
    logic       collect_pulse_b, all_collected_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] mask;
        logic [7:0] score;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    coin_round_controller dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .char_left(char_left), .char_top(char_top),
        .coin_display(coin_display_a), .score(score_a), .collect_pulse(collect_pulse_a),
        .collect_mask(collect_mask_a), .all_collected(all_collected_a), .round(round_a)
    );

    coin_round_controller #(.CHAR_W(40), .RESPAWN_FRAMES(3)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .char_left(char_left), .char_top(char_top),
        .coin_display(coin_display_b), .score(score_b), .collect_pulse(collect_pulse_b),
        .collect_mask(collect_mask_b), .all_collected(all_collected_b), .round(round_b)
    );

    // Every collect pulse on dut_a must match the next expected entry.
    always @(negedge clk) begin
        if (collect_pulse_a === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pulse: got mask %b score %0d, required no pulse",
                         collect_mask_a, score_a);
            end else begin
                mon_e = sb_q.pop_front();
                if (collect_mask_a !== mon_e.mask || score_a !== mon_e.score) begin
                    errors++;
                    $display("FAIL sb_pulse: got mask %b score %0d, required mask %b score %0d",
                             collect_mask_a, score_a, mon_e.mask, mon_e.score);
                end
            end
        end else if (collect_mask_a !== 4'b0000 && reset === 1'b0) begin
            checks++;
            errors++;
            $display("FAIL sb_mask_idle: got mask %b, required 0000", collect_mask_a);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        cyc(2);
        checks++;
        if ({coin_display_a, score_a, collect_pulse_a, collect_mask_a, all_collected_a, round_a}
            !== 22'd0) begin
            errors++;
            $display("FAIL reset_vals: got disp %b score %0d round %0d, required all zero",
                     coin_display_a, score_a, round_a);
        end
        reset = 1'b0;
        char_left = 10'd90;
        char_top = 10'd60;
        do_tick();
        cyc(3);
        checks++;
        if (coin_display_a !== 4'b0000 || score_a !== 8'd0) begin
            errors++;
            $display("FAIL idle_tick: got disp %b score %0d, required 0000 0",
                     coin_display_a, score_a);
        end
        // Reset lands between S0 and S2 of a hitting frame.
        do_start();
        do_tick();
        cyc(1);
        reset = 1'b1;
        #1;
        checks++;
        if ({coin_display_a, score_a, collect_pulse_a, collect_mask_a, all_collected_a, round_a}
            !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid: got disp %b score %0d, required all zero",
                     coin_display_a, score_a);
        end
        cyc(1);
        reset = 1'b0;
        cyc(4);
        checks++;
        if (coin_display_a !== 4'b0000 || score_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_after: got disp %b score %0d, required 0000 0",
                     coin_display_a, score_a);
        end
    endtask

    task automatic test_single_coin();
        do_start();
        checks++;
        if (coin_display_a !== 4'b1111 || score_a !== 8'd0 || round_a !== 4'd0) begin
            errors++;
            $display("FAIL start_vals: got disp %b score %0d round %0d, required 1111 0 0",
                     coin_display_a, score_a, round_a);
        end
        char_left = 10'd90;
        char_top = 10'd60;
        sb_q.push_back('{mask: 4'b1000, score: 8'd1});
        do_tick();
        cyc(1);
        checks++;
        if (coin_display_a !== 4'b1111) begin
            errors++;
            $display("FAIL single_latency: got disp %b one cycle in, required 1111",
                     coin_display_a);
        end
        cyc(1);
        checks++;
        if (coin_display_a !== 4'b0111 || score_a !== 8'd1 || collect_pulse_a !== 1'b1) begin
            errors++;
            $display("FAIL single_hit: got disp %b score %0d pulse %b, required 0111 1 1",
                     coin_display_a, score_a, collect_pulse_a);
        end
        cyc(1);
        checks++;
        if (collect_pulse_a !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_len: got pulse %b, required 0", collect_pulse_a);
        end
        do_tick();
        cyc(3);
        checks++;
        if (coin_display_a !== 4'b0111 || score_a !== 8'd1) begin
            errors++;
            $display("FAIL single_rescore: got disp %b score %0d, required 0111 1",
                     coin_display_a, score_a);
        end
    endtask

    task automatic test_coin1_and_miss();
        do_start();
        char_left = 10'd140;
        char_top = 10'd60;
        sb_q.push_back('{mask: 4'b0100, score: 8'd1});
        do_tick();
        cyc(2);
        checks++;
        if (coin_display_a !== 4'b1011 || collect_mask_a !== 4'b0100) begin
            errors++;
            $display("FAIL coin1_hit: got disp %b mask %b, required 1011 0100",
                     coin_display_a, collect_mask_a);
        end
        char_top = 10'd100;
        do_tick();
        cyc(3);
        checks++;
        if (coin_display_a !== 4'b1011 || score_a !== 8'd1) begin
            errors++;
            $display("FAIL below_miss: got disp %b score %0d, required 1011 1",
                     coin_display_a, score_a);
        end
    endtask

    // dut_b (CHAR_W=40, RESPAWN_FRAMES=3): double hit, clear the round, then respawn.
    task automatic test_wide_and_respawn();
        do_start();
        char_left = 10'd120;
        char_top = 10'd60;
        sb_q.push_back('{mask: 4'b1000, score: 8'd1});
        do_tick();
        cyc(2);
        checks++;
        if (collect_pulse_b !== 1'b1 || collect_mask_b !== 4'b1100 || score_b !== 8'd2) begin
            errors++;
            $display("FAIL wide_double: got pulse %b mask %b score %0d, required 1 1100 2",
                     collect_pulse_b, collect_mask_b, score_b);
        end
        char_left = 10'd230;
        sb_q.push_back('{mask: 4'b0010, score: 8'd2});
        do_tick();
        cyc(2);
        checks++;
        if (collect_mask_b !== 4'b0011 || coin_display_b !== 4'b0000 ||
            all_collected_b !== 1'b1 || round_b !== 4'd1 || score_b !== 8'd4) begin
            errors++;
            $display("FAIL cleared: got mask %b disp %b all %b round %0d score %0d, req 0011 0000 1 1 4",
                     collect_mask_b, coin_display_b, all_collected_b, round_b, score_b);
        end
        do_tick();
        cyc(1);
        do_tick();
        cyc(1);
        checks++;
        if (all_collected_b !== 1'b1 || coin_display_b !== 4'b0000) begin
            errors++;
            $display("FAIL respawn_early: got all %b disp %b after 2 ticks, required 1 0000",
                     all_collected_b, coin_display_b);
        end
        do_tick();
        checks++;
        if (coin_display_b !== 4'b1111 || all_collected_b !== 1'b0 || score_b !== 8'd4 ||
            round_b !== 4'd1) begin
            errors++;
            $display("FAIL respawn: got disp %b all %b score %0d round %0d, required 1111 0 4 1",
                     coin_display_b, all_collected_b, score_b, round_b);
        end
        cyc(3);
    endtask

    task automatic test_back_to_back();
        do_start();
        char_left = 10'd90;
        char_top = 10'd60;
        sb_q.push_back('{mask: 4'b1000, score: 8'd1});
        frame_tick = 1'b1;
        cyc(1);
        char_left = 10'd140;
        cyc(1);
        frame_tick = 1'b0;
        cyc(5);
        checks++;
        if (coin_display_a !== 4'b0111 || score_a !== 8'd1) begin
            errors++;
            $display("FAIL busy_ignore: got disp %b score %0d, required 0111 1",
                     coin_display_a, score_a);
        end
        // start collides with the S2 edge of a hitting frame.
        char_left = 10'd140;
        do_tick();
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        checks++;
        if (coin_display_a !== 4'b1111 || score_a !== 8'd0 || collect_pulse_a !== 1'b0) begin
            errors++;
            $display("FAIL start_vs_s2: got disp %b score %0d pulse %b, required 1111 0 0",
                     coin_display_a, score_a, collect_pulse_a);
        end
        checks++;
        if (round_b !== 4'd0 || coin_display_b !== 4'b1111) begin
            errors++;
            $display("FAIL start_round: got round %0d disp %b, required 0 1111",
                     round_b, coin_display_b);
        end
        cyc(4);
    endtask

    initial begin
        test_reset();
        test_single_coin();
        test_coin1_and_miss();
        test_wide_and_respawn();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending pulses, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
